// File: rtl/alu_pkg.sv
// Shared types for the arbitrated ADD/SUB/MUL unit: operator and FSM encodings plus the
// holding-register layout.
package alu_pkg;

    // Upper bounds that size the holding register; instances use the low W / ID bits.
    localparam int unsigned W_MAX    = 64;
    localparam int unsigned ID_W_MAX = 3;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        MUL = 2'b10
    } operator_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    typedef struct packed {
        operator_t             op;
        logic [W_MAX-1:0]      a;
        logic [W_MAX-1:0]      b;
        logic [W_MAX-1:0]      z;
        logic [ID_W_MAX-1:0]   id;
    } opcode_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between NREQ requesters (master) and the shared ALU arbiter (slave).
interface alu_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 32
);
    localparam int unsigned ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ-1:0][1:0]    req_op;
    logic [NREQ-1:0][W-1:0]  req_a;
    logic [NREQ-1:0][W-1:0]  req_b;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [ID_W-1:0]         rsp_id;
    logic [W-1:0]            rsp_z;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_z
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_z
    );

endinterface

// File: rtl/alu_core.sv
// Purely combinational arithmetic unit; results wrap modulo 2^W, unknown op yields zero.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  operator_t      op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [W-1:0]   z
);

    always_comb begin
        z = '0;
        case (op)
            ADD:     z = a + b;
            SUB:     z = a - b;
            MUL:     z = a * b;
            default: z = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one alu_core among NREQ requesters; one op in flight at a time,
// result returned tagged with the requester index over a valid/ready channel.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned NREQ    = 4,   // 2..8
    parameter int unsigned W       = 32,  // <= W_MAX
    parameter int unsigned MUL_LAT = 3    // >= 1
) (
    input  logic           clk,
    input  logic           rst,
    alu_arbiter_if.slave   bus
);

    localparam int unsigned ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CNT_W = $clog2(MUL_LAT + 1);

    state_t              state_q;
    logic [ID_W-1:0]     last_grant_q;
    logic [CNT_W-1:0]    cnt_q;
    opcode_t             hold_q;
    logic                rsp_valid_q;
    logic [ID_W-1:0]     rsp_id_q;

    logic                gnt_found;
    logic [ID_W-1:0]     gnt_idx;
    logic [W-1:0]        core_z;

    // Search upward from the requester after the last grant, wrapping at NREQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = last_grant_q;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            logic [ID_W-1:0] cand;
            cand = ID_W'((32'(last_grant_q) + k) % NREQ);
            if (!gnt_found && bus.req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (state_q == IDLE && gnt_found) begin
            bus.req_ready[gnt_idx] = 1'b1;
        end
    end

    alu_core #(
        .W (W)
    ) u_core (
        .op (hold_q.op),
        .a  (hold_q.a[W-1:0]),
        .b  (hold_q.b[W-1:0]),
        .z  (core_z)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(NREQ - 1);
            cnt_q        <= '0;
            hold_q       <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (gnt_found) begin
                        hold_q.op    <= operator_t'(bus.req_op[gnt_idx]);
                        hold_q.a     <= W_MAX'(bus.req_a[gnt_idx]);
                        hold_q.b     <= W_MAX'(bus.req_b[gnt_idx]);
                        hold_q.id    <= ID_W_MAX'(gnt_idx);
                        last_grant_q <= gnt_idx;
                        cnt_q        <= (operator_t'(bus.req_op[gnt_idx]) == MUL) ?
                                        CNT_W'(MUL_LAT) : CNT_W'(1);
                        state_q      <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt_q == CNT_W'(1)) begin
                        hold_q.z    <= W_MAX'(core_z);
                        rsp_id_q    <= ID_W'(hold_q.id);
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_z     = hold_q.z[W-1:0];

    // Holding register is sized for the widest configuration; upper bits are don't-care.
    logic unused_hold;
    assign unused_hold = ^{hold_q.a, hold_q.b, hold_q.z, hold_q.id};

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: transaction-level reference model checked every cycle,
// plus hand-computed literal expectations for latency, results and grant order.
module tb_alu_arbiter;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned W       = 32;
    localparam int unsigned MUL_LAT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

    alu_arbiter #(
        .NREQ    (NREQ),
        .W       (W),
        .MUL_LAT (MUL_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction, counted in cycles until its response.
    int           m_last  = NREQ - 1;
    int           m_left  = 0;
    bit           m_valid = 1'b0;
    logic [W-1:0] m_z     = '0;
    int           m_id    = 0;
    logic [W-1:0] m_pz;
    int           m_pid;
    int           m_g;

    function automatic int pick();
        for (int k = 1; k <= int'(NREQ); k++) begin
            int i;
            i = (m_last + k) % NREQ;
            if (bus.req_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] calc(input logic [1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a * b;
            default: return '0;
        endcase
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_left = 0; m_valid = 1'b0; m_z = '0; m_id = 0; m_last = NREQ - 1;
        end else if (m_valid) begin
            if (bus.rsp_ready) m_valid = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_valid = 1'b1; m_z = m_pz; m_id = m_pid;
            end
        end else begin
            m_g = pick();
            if (m_g >= 0) begin
                m_last = m_g;
                m_pid  = m_g;
                m_pz   = calc(bus.req_op[m_g], bus.req_a[m_g], bus.req_b[m_g]);
                m_left = (bus.req_op[m_g] == 2'd2) ? MUL_LAT : 1;
            end
        end
    end

    // Every-cycle comparison against the model, plus a grant log for literal checks.
    int g_idx_q[$];
    int g_cyc_q[$];

    always @(negedge clk) begin
        logic [NREQ-1:0] exp_rdy;
        int g;
        if (chk_en) begin
            exp_rdy = '0;
            if (!m_valid && m_left == 0) begin
                g = pick();
                if (g >= 0) exp_rdy[g] = 1'b1;
            end
            chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
            chk("req_ready onehot0", 64'($onehot0(bus.req_ready)), 64'd1);
            chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_valid));
            chk("rsp_z", 64'(bus.rsp_z), 64'(m_z));
            chk("rsp_id", 64'(bus.rsp_id), 64'(m_id));
        end
        for (int i = 0; i < int'(NREQ); i++) begin
            if (bus.req_ready[i] && bus.req_valid[i]) begin
                g_idx_q.push_back(i);
                g_cyc_q.push_back(cyc);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int i, output bit ok);
        int n;
        n = 0;
        #1;
        while (!bus.req_ready[i] && n < 20) begin
            @(posedge clk); #1; n++;
        end
        ok = bus.req_ready[i];
    endtask

    task automatic do_op(input string name, input int i, input logic [1:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input int exp_lat, input logic [W-1:0] exp_z);
        bit ok;
        int lat;
        bus.req_valid[i] = 1'b1;
        bus.req_op[i]    = op;
        bus.req_a[i]     = a;
        bus.req_b[i]     = b;
        wait_ready(i, ok);
        chk({name, " accepted"}, 64'(ok), 64'd1);
        @(posedge clk); #1;
        bus.req_valid[i] = 1'b0;
        bus.req_a[i]     = '1;  // operands only need to hold on the accept edge
        bus.req_b[i]     = '1;
        lat = 0;
        while (!bus.rsp_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        chk({name, " latency"}, 64'(lat), 64'(exp_lat));
        chk({name, " z"}, 64'(bus.rsp_z), 64'(exp_z));
        chk({name, " id"}, 64'(bus.rsp_id), 64'(i));
    endtask

    initial begin
        #(200000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n;
        bit seen;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        rst = 1'b1;
        step(2);
        chk_en = 1'b1;
        chk("reset req_ready", 64'(bus.req_ready), 64'd0);
        chk("reset rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("reset rsp_z", 64'(bus.rsp_z), 64'd0);
        chk("reset rsp_id", 64'(bus.rsp_id), 64'd0);
        rst = 1'b0;
        step(1);

        do_op("add 50+30", 0, 2'd0, 32'd50, 32'd30, 1, 32'd80);
        step(1);
        do_op("sub 50-30", 1, 2'd1, 32'd50, 32'd30, 1, 32'd20);
        step(1);
        do_op("sub 30-50", 3, 2'd1, 32'd30, 32'd50, 1, 32'hFFFF_FFEC);
        step(1);
        do_op("mul 50*30", 2, 2'd2, 32'd50, 32'd30, 3, 32'd1500);
        step(1);
        do_op("mul wrap", 1, 2'd2, 32'h0001_0000, 32'h0001_0000, 3, 32'd0);
        step(1);

        // All requesters valid from reset: expect 0,1,2,3,0 at one grant per 3 cycles.
        rst = 1'b1;
        for (int i = 0; i < int'(NREQ); i++) begin
            bus.req_valid[i] = 1'b1;
            bus.req_op[i]    = 2'd0;
            bus.req_a[i]     = 32'(i);
            bus.req_b[i]     = 32'd10;
        end
        step(1);
        g_idx_q.delete();
        g_cyc_q.delete();
        rst = 1'b0;
        n = 0;
        while (g_idx_q.size() < 5 && n < 40) begin
            step(1); n++;
        end
        bus.req_valid = '0;
        chk("rr grant count", 64'(g_idx_q.size() >= 5), 64'd1);
        if (g_idx_q.size() >= 5) begin
            chk("rr grant 0", 64'(g_idx_q[0]), 64'd0);
            chk("rr grant 1", 64'(g_idx_q[1]), 64'd1);
            chk("rr grant 2", 64'(g_idx_q[2]), 64'd2);
            chk("rr grant 3", 64'(g_idx_q[3]), 64'd3);
            chk("rr grant 4", 64'(g_idx_q[4]), 64'd0);
            chk("rr spacing", 64'(g_cyc_q[4] - g_cyc_q[0]), 64'd12);
        end
        step(5);

        // Backpressure: stall in RESP with another requester waiting.
        bus.rsp_ready = 1'b0;
        do_op("stall add", 1, 2'd0, 32'd7, 32'd8, 1, 32'd15);
        bus.req_valid[2] = 1'b1;
        bus.req_op[2]    = 2'd0;
        for (int k = 0; k < 5; k++) begin
            step(1);
            chk("stall rsp_valid", 64'(bus.rsp_valid), 64'd1);
            chk("stall rsp_z", 64'(bus.rsp_z), 64'd15);
            chk("stall rsp_id", 64'(bus.rsp_id), 64'd1);
            chk("stall req_ready", 64'(bus.req_ready), 64'd0);
        end
        bus.rsp_ready = 1'b1;
        step(1);
        chk("release rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("release idle grant", 64'(bus.req_ready), 64'b0100);
        bus.req_valid[2] = 1'b0;  // withdrawn before its accept edge
        step(3);

        // Reset during MUL EXEC discards the op; pointer returns to requester 0.
        bus.req_valid[1] = 1'b1;
        bus.req_op[1]    = 2'd2;
        bus.req_a[1]     = 32'd5;
        bus.req_b[1]     = 32'd6;
        wait_ready(1, ok);
        chk("rst-mul accepted", 64'(ok), 64'd1);
        @(posedge clk); #1;
        bus.req_valid[1] = 1'b0;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("post-reset rsp_z", 64'(bus.rsp_z), 64'd0);
        seen = 1'b0;
        for (int k = 0; k < int'(MUL_LAT) + 2; k++) begin
            if (bus.rsp_valid) seen = 1'b1;
            step(1);
        end
        chk("no rsp after reset", 64'(seen), 64'd0);
        g_idx_q.delete();
        g_cyc_q.delete();
        bus.req_valid = 4'b0101;
        bus.req_op    = '0;
        n = 0;
        while (g_idx_q.size() < 1 && n < 20) begin
            step(1); n++;
        end
        bus.req_valid = '0;
        chk("post-reset first grant", 64'(g_idx_q.size() >= 1 ? g_idx_q[0] : 99), 64'd0);
        step(4);

        do_op("undefined op", 0, 2'd3, 32'd123, 32'd456, 1, 32'd0);
        step(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares a single ADD/SUB/MUL arithmetic unit among `NREQ` requesters using round-robin arbitration. It captures one operation per grant and sequences it through a fixed per-operation execution latency. It then returns the result, tagged with the requester index, over a valid/ready response channel. It sits between the requesting datapath blocks and the shared `alu_core`.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8
- `W`, 32: operand/result width
- `MUL_LAT`, 3: EXEC cycles for MUL, ≥1

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset (one clock, sync reset, active high)
- `req_valid`  in  NREQ  per-requester request valid
- `req_ready`  out  NREQ  per-requester accept; at most one bit high
- `req_op`  in  NREQ×2  per-requester `operator_t`
- `req_a`, `req_b`  in  NREQ×W  per-requester operands, two's complement
- `rsp_valid`  out  1  result valid
- `rsp_ready`  in  1  downstream accepts result
- `rsp_id`  out  $clog2(NREQ)  requester index of result
- `rsp_z`  out  W  result

## Operation
FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant goes to the first requester i with `req_valid[i]` high, searching upward from `last_grant+1` modulo NREQ.
  - `req_ready[g]` is driven combinationally high for that requester only.
  - On that edge: capture op/a/b/g into the `opcode_t` holding register, set `last_grant = g`, load the cycle counter, and go to EXEC.
  - With no valid request, remain in IDLE with all `req_ready` low.
- EXEC:
  - Counter loads 1 for ADD/SUB and `MUL_LAT` for MUL.
  - The counter decrements each cycle. When it reaches 1, latch `rsp_z` from `alu_core`, set `rsp_id = g`, and go to RESP.
- RESP:
  - `rsp_valid` is held high, and `rsp_z`/`rsp_id` are held stable until `rsp_ready` is high on an edge.
  - On that edge, go to IDLE.
- Arithmetic:
  - ADD gives a+b; SUB gives a−b; MUL gives the low W bits of a×b.
  - All results wrap modulo 2^W.
  - Undefined op encoding 2'b11 produces z=0 and still responds.
- Requester behaviour:
  - A requester may drop `req_valid` without being granted; nothing is captured.
  - Operands need only be valid on the accept edge.
- No new request is accepted while in EXEC or RESP. `req_ready` is all zeros in those states.

## Timing
- Reset values:
  - state IDLE
  - `last_grant = NREQ−1`, so requester 0 wins first
  - `rsp_valid`, `rsp_id`, `rsp_z` = 0
  - `req_ready` = 0
- Latency from accept edge T to first cycle with `rsp_valid` high:
  - ADD/SUB: `rsp_valid` rises at edge T+1.
  - MUL: `rsp_valid` rises at edge T+MUL_LAT.
- Throughput with `rsp_ready` tied high: one ADD/SUB every 3 cycles (IDLE, EXEC, RESP).
- Simultaneous requests: the round-robin pointer guarantees every valid requester is granted within NREQ grants.
- Backpressure: with `rsp_ready` low, the block stalls indefinitely in RESP and outputs do not change.
- Reset mid-operation: the in-flight op is discarded and no response is produced. The next cycle shows reset values.

## Structure
- Package `alu_pkg`:
  - `operator_t` (enum logic [1:0] {ADD, SUB, MUL})
  - `opcode_t` (packed struct: op, a, b, z, id)
  - state enum
- Sub-module `alu_core`: purely combinational, takes op/a/b and produces z. It is instantiated once.
- The FSM, arbiter and counter live in `alu_arbiter`.

## Test plan
- Single request ADD from requester 0, a=50, b=30, `rsp_ready` high → `rsp_valid` at accept+1, `rsp_z`=80, `rsp_id`=0.
- SUB a=50, b=30 → 20. SUB a=30, b=50 → 0xFFFFFFEC (−20).
- MUL from requester 2, a=50, b=30, MUL_LAT=3 → `rsp_valid` at accept+3, `rsp_z`=1500, `rsp_id`=2. MUL 0x10000×0x10000 → 0 (wrap).
- All 4 requesters hold `req_valid` continuously from reset → grant order 0,1,2,3,0. Each `req_ready` pulse lasts exactly one cycle, and `req_ready` is never multi-hot.
- Hold `rsp_ready` low for 5 cycles in RESP → `rsp_valid`, `rsp_z` and `rsp_id` stay stable and `req_ready` stays 0. Raise `rsp_ready` → return to IDLE next edge.
- Assert `rst` during MUL EXEC → no `rsp_valid`. After reset, requester 0 is granted first. Op 2'b11 → `rsp_z`=0 with response.
